// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: byte-wise instruction fetcher feeding the fetch-op queue
// with static JAL-follow / JALR-stall prediction.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic [7:0]  mem_din,
  input  logic        foq_full,
  output logic [31:0] inst_out,
  output logic [31:0] addr_out,
  output logic        inst_out_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {REQ, READ, HOLD, WAIT_JALR} state_t;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] word_q;
  logic [2:0]  k_q;
  logic [31:0] jal_imm;
  logic [1:0]  a_off;
  assign jal_imm = {{12{word_q[31]}}, word_q[19:12], word_q[20], word_q[30:21], 1'b0};
  // k=4 only captures the last byte; its address is don't-care, so reuse +3
  assign a_off = k_q[2] ? 2'd3 : k_q[1:0];
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      k_q     <= '0;
      word_q  <= '0;
    end else if (redirect_valid) begin
      state_q <= REQ;
      pc_q    <= redirect_pc;
      k_q     <= '0;
      word_q  <= '0;
    end else if (rdy_in) begin
      case (state_q)
        REQ: if (mem_gnt) begin
          state_q <= READ;
          k_q     <= '0;
        end
        READ: begin
          if (k_q != 3'd0) word_q[{k_q[1:0] - 2'd1, 3'b000} +: 8] <= mem_din;
          k_q <= k_q + 3'd1;
          if (k_q == 3'd4) state_q <= HOLD;
        end
        HOLD: if (!foq_full) begin
          state_q <= word_q[6:0] == OP_JALR ? WAIT_JALR : REQ;
          pc_q    <= word_q[6:0] == OP_JAL  ? pc_q + jal_imm :
                     word_q[6:0] == OP_JALR ? pc_q : pc_q + 32'd4;
        end
        default: ;
      endcase
    end
  end
  assign mem_wr         = 1'b0;
  assign mem_req        = rst_in & (state_q == REQ || state_q == READ);
  assign mem_a          = rst_in ? pc_q + (state_q == READ ? {30'b0, a_off} : 32'd0) : 32'd0;
  assign inst_out       = word_q;
  assign addr_out       = rst_in ? pc_q : 32'd0;
  assign inst_out_valid = rst_in & rdy_in & ~redirect_valid & ~foq_full & (state_q == HOLD);
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of fetch timing, prediction, stalls,
// redirects and reset for inst_fetch_unit.
module tb_inst_fetch_unit;
  logic        clk_in = 0, rst_in = 0, rdy_in = 1, mem_gnt = 1, foq_full = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic [7:0]  mem_din = 0;
  logic        mem_req, mem_wr, inst_out_valid;
  logic [31:0] mem_a, inst_out, addr_out;
  logic [7:0]  mem [4096];
  int          n_chk = 0, n_fail = 0, lat;

  inst_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_wr(mem_wr), .mem_din(mem_din),
    .foq_full(foq_full), .inst_out(inst_out), .addr_out(addr_out),
    .inst_out_valid(inst_out_valid), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  // one-cycle read latency; the memory stalls together with the fetcher
  always @(posedge clk_in) if (rdy_in) mem_din <= mem[mem_a[11:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[(a[11:0] + i) & 12'hFFF] = w[8*i +: 8];
  endtask

  task automatic fetch(input string tag, input logic [31:0] ei, input logic [31:0] ea, output int n);
    n = 0;
    #1;
    while (!inst_out_valid && n < 40) begin
      @(negedge clk_in); #1;
      n++;
    end
    chk({tag, " valid"}, {31'b0, inst_out_valid}, 32'd1);
    chk({tag, " inst"}, inst_out, ei);
    chk({tag, " addr"}, addr_out, ea);
  endtask

  task automatic next_req(input string tag, input logic [31:0] ea);
    @(negedge clk_in); #1;
    chk({tag, " one push"}, {31'b0, inst_out_valid}, 32'd0);
    chk({tag, " req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, " mem_a"}, mem_a, ea);
  endtask

  task automatic redir(input string tag, input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc    = pc;
    #1;
    chk({tag, " no push"}, {31'b0, inst_out_valid}, 32'd0);
    @(negedge clk_in);
    redirect_valid = 0;
    #1;
    chk({tag, " req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, " mem_a"}, mem_a, pc);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    put(32'h000, 32'h0010_0513);
    put(32'h004, 32'h00C0_006F);
    put(32'h00C, 32'hAABB_CCDD);
    put(32'h010, 32'h0100_006F);
    put(32'h020, 32'h0200_006F);
    put(32'h040, 32'h0000_8067);
    put(32'h100, 32'h0000_0463);
    put(32'h200, 32'h1234_5037);
    put(32'h204, 32'h0000_0013);
    put(32'hFFC, 32'h0000_0013);

    @(negedge clk_in); #1;
    chk("rst mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst mem_a", mem_a, 32'd0);
    chk("rst mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst inst", inst_out, 32'd0);
    chk("rst addr", addr_out, 32'd0);
    chk("rst valid", {31'b0, inst_out_valid}, 32'd0);
    @(negedge clk_in);
    rst_in = 1;
    fetch("first", 32'h0010_0513, 32'h0, lat);
    chk("first latency", lat, 32'd6);
    next_req("after first", 32'h4);

    foq_full = 1;
    repeat (6) @(negedge clk_in);
    #1;
    for (int i = 0; i < 7; i++) begin
      chk("full valid", {31'b0, inst_out_valid}, 32'd0);
      chk("full inst", inst_out, 32'h00C0_006F);
      chk("full addr", addr_out, 32'h4);
      @(negedge clk_in); #1;
    end
    foq_full = 0;
    fetch("released", 32'h00C0_006F, 32'h4, lat);
    chk("released latency", lat, 32'd0);
    next_req("jal +12", 32'h10);

    fetch("jal +16", 32'h0100_006F, 32'h10, lat);
    next_req("jal +16", 32'h20);
    fetch("jal +32", 32'h0200_006F, 32'h20, lat);
    next_req("jal +32", 32'h40);

    fetch("jalr", 32'h0000_8067, 32'h40, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in); #1;
      chk("jalr wait", {30'b0, mem_req, inst_out_valid}, 32'd0);
    end
    redir("jalr redirect", 32'h100);

    fetch("branch", 32'h0000_0463, 32'h100, lat);
    next_req("branch not taken", 32'h104);
    repeat (3) @(negedge clk_in);
    #1;
    chk("k2 mem_a", mem_a, 32'h106);
    redir("mid read", 32'h200);
    fetch("after mid redirect", 32'h1234_5037, 32'h200, lat);
    next_req("lui", 32'h204);

    fetch("nop 204", 32'h0000_0013, 32'h204, lat);
    put(32'h010, 32'hFFDF_F06F);
    redir("hold redirect", 32'h10);
    fetch("jal -4", 32'hFFDF_F06F, 32'h10, lat);
    next_req("jal -4", 32'h0C);

    repeat (2) @(negedge clk_in);
    rdy_in = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall mem_a", mem_a, 32'h0D);
      chk("stall req", {31'b0, mem_req}, 32'd1);
      chk("stall valid", {31'b0, inst_out_valid}, 32'd0);
      @(negedge clk_in); #1;
    end
    chk("stall end mem_a", mem_a, 32'h0D);
    rdy_in = 1;
    fetch("after stall", 32'hAABB_CCDD, 32'h0C, lat);
    next_req("after stall", 32'h10);

    repeat (2) @(negedge clk_in);
    #2;
    rst_in = 0;
    #1;
    chk("mid rst mem_req", {31'b0, mem_req}, 32'd0);
    chk("mid rst mem_a", mem_a, 32'd0);
    chk("mid rst valid", {31'b0, inst_out_valid}, 32'd0);
    chk("mid rst addr", addr_out, 32'd0);
    chk("mid rst inst", inst_out, 32'd0);
    @(negedge clk_in);
    rst_in = 1;
    fetch("refetch", 32'h0010_0513, 32'h0, lat);
    chk("refetch latency", lat, 32'd6);
    next_req("refetch", 32'h4);

    redir("wrap redirect", 32'hFFFF_FFFC);
    fetch("wrap", 32'h0000_0013, 32'hFFFF_FFFC, lat);
    next_req("wrap", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Producer side of the fetch-op queue: reads instruction bytes from the shared byte-wide memory port, assembles 32-bit little-endian words, and pushes each word with its PC.
- Output goes to the predecoder, which drives the queue's push port; `foq_full` back-pressures this block.
- Static prediction: JAL is followed in-fetcher, branches are predicted not-taken, and JALR halts fetch until redirect.
- `redirect_valid` arrives on the same cycle as the queue's `predict_fail`.

Parameters:
RESET_PC  32'h0000_0000  PC fetched after reset

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous reset, active-low
rdy_in  input  1  global ready; low = pause
mem_req  output  1  request ownership of memory port
mem_gnt  input  1  memory port granted this cycle
mem_a  output  32  byte read address
mem_wr  output  1  write enable; constant 0
mem_din  input  8  read data; byte for address presented in cycle t is valid in cycle t+1
foq_full  input  1  queue full
inst_out  output  32  assembled instruction
addr_out  output  32  PC of inst_out
inst_out_valid  output  1  push strobe to predecoder/queue
redirect_valid  input  1  misprediction/JALR resolution
redirect_pc  input  32  new fetch PC

Behaviour:
- Reset (`rst_in`=0, async): state=REQ, pc=RESET_PC, byte counter k=0, assembly register=0.
  - Outputs during reset: mem_req=0, mem_a=0, mem_wr=0, inst_out=0, addr_out=0, inst_out_valid=0.
- States:
  - REQ: mem_req=1. If mem_gnt, go to READ with k=0.
  - READ: mem_req=1, mem_a=pc+k for k=0..3.
    - For k=1..4, capture mem_din into byte k-1 of the word.
    - k increments each cycle. After the k=4 capture, go to HOLD.
    - From grant to HOLD is 5 cycles. mem_a during k=4 = pc+3 (don't care).
  - HOLD: mem_req=0, inst_out=word, addr_out=pc, inst_out_valid=!foq_full.
    - On a push cycle (valid=1), next pc is chosen by the word's opcode:
      - JAL (7'b1101111): pc+{{12{i[31]}},i[19:12],i[20],i[30:21],1'b0}, go to REQ.
      - JALR (7'b1100111): pc unchanged, go to WAIT_JALR.
      - Otherwise, including branches: pc+4, go to REQ.
    - If foq_full, stay in HOLD with outputs stable.
  - WAIT_JALR: mem_req=0, inst_out_valid=0. Leave only on redirect.
- inst_out_valid is combinational from state/foq_full/rdy_in/redirect_valid. The queue samples at the same posedge the FSM advances, so exactly one push per word.
- Redirect (any state, acts even when `rdy_in`=0):
  - Next cycle: pc=redirect_pc, state=REQ, k=0, assembly cleared.
  - In-flight byte reads are discarded; mem_req drops for that cycle's remainder only via the state change.
  - In the redirect cycle inst_out_valid is forced 0; redirect beats push.
- rdy_in=0 (no redirect): all registers hold, inst_out_valid=0, mem_a/mem_req hold their values.
  - A READ sequence resumes at the same k. The memory side must also stall under `rdy_in`.
- mem_gnt is sampled only in REQ; the grant is held implicitly for READ.
- Arithmetic: all PC math is 32-bit wrap-around (0xFFFF_FFFC+4=0). No alignment check; pc[1:0] is used as-is.
- mem_wr is always 0.

Test Plan:
- Reset release with RESET_PC=0, mem_gnt=1, memory bytes 0..3 = 13 05 10 00 -> 5 cycles after grant, HOLD with inst_out=32'h00100513, addr_out=0, one-cycle inst_out_valid; next REQ pc=4.
- foq_full=1 for 7 cycles during HOLD -> inst_out_valid=0, inst_out/addr_out stable; foq_full drops -> exactly one push, then pc advances.
- JAL 32'h0100006F at pc=0x10 -> push addr_out=0x10, next fetch mem_a=0x20; JAL imm=-4 (32'hFFDFF06F) at 0x10 -> next fetch 0x0C.
- JALR 32'h00008067 at 0x40 -> push, WAIT_JALR with mem_req=0 for 20 cycles; redirect_pc=0x100 -> next cycle REQ, then fetch from 0x100.
- redirect_valid at READ k=2 with redirect_pc=0x200 -> no push of the partial word; next read sequence starts at mem_a=0x200; redirect coincident with HOLD&!foq_full -> inst_out_valid=0.
- rdy_in low for 3 cycles at READ k=1 -> k, mem_a, inst_out_valid=0 held; resumes and assembles the correct word; async reset asserted mid-READ -> immediate reset outputs, fetch restarts at RESET_PC.
